// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Reusable pipeline-stage register (ID/EXE, EXE/MEM, MEM/WB boundaries).
//   Moves an opaque payload plus a control vector under a valid/ready
//   handshake. SKID=1 adds a second entry so in_ready comes from a flop and
//   the stage still sustains one beat per cycle under back-pressure.
//   SKID=0 is a single entry with a combinational in_ready.
//   flush turns every held entry, and any beat offered that cycle, into a
//   bubble. A bubble never drives a KILL_MASK (side-effect) control bit.
//
// Ports
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   flush      drop held entries and the beat offered this cycle
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_data    upstream payload         [DATA_W]
//   in_ctrl    upstream control vector  [CTRL_W]
//   out_valid  downstream beat valid
//   out_ready  downstream accepts beat
//   out_data   main-entry payload       [DATA_W]
//   out_ctrl   main-entry control, side-effect bits gated by valid [CTRL_W]
//   stall_cnt  saturating count of cycles with out_valid && !out_ready [CNT_W]
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 96,
    parameter int unsigned       CTRL_W    = 16,
    parameter logic [CTRL_W-1:0] KILL_MASK = '0,
    parameter int                SKID      = 1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main entry (drives the outputs) and skid entry (only used when SKID=1).
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic accept;
    logic issue;

    // With a skid entry the stage refuses only when both entries are full,
    // which is exactly when the skid entry holds a beat.
    assign in_ready = (SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = m_valid_q && out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;

        if (flush) begin
            // Payload is held; only the valids drop. The offered beat is
            // consumed and discarded.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || issue) begin
            if (s_valid_q) begin
                // Older skid beat advances first to keep FIFO order.
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_ctrl_d  = s_ctrl_q;
                s_valid_d = accept;
                if (accept) begin
                    s_data_d = in_data;
                    s_ctrl_d = in_ctrl;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_data_d = in_data;
                    m_ctrl_d = in_ctrl;
                end
            end
        end else if ((SKID != 0) && accept) begin
            // Main entry is stalled; the beat accepted on the registered
            // in_ready lands in the skid entry.
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (m_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_ctrl_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ctrl_q  <= s_ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    // A bubble keeps its stale control bits but never its side effects.
    assign out_ctrl  = m_valid_q ? m_ctrl_q : (m_ctrl_q & ~KILL_MASK);
    assign stall_cnt = cnt_q;

endmodule
